// File: rtl/stepdown_fault_seq.sv
// Step-down converter fault sequencer.
// Qualifies asynchronous fault comparator outputs with a 2-flop synchronizer and a per-bit debounce
// counter. It then sequences the power-stage enable through soft-start, run, hiccup retry and
// latched-off states.
module stepdown_fault_seq #(
  parameter int NF         = 4,
  parameter int DB_CYC     = 8,
  parameter int SS_CYC     = 256,
  parameter int HICCUP_CYC = 1024,
  parameter int MAX_RETRY  = 3,
  parameter int CW         = 12
) (
  input  logic                           CELCLK,
  input  logic                           CELRSTN,
  input  logic                           en,
  input  logic [NF-1:0]                  fault_raw,
  input  logic                           clr,
  output logic                           pwr_en,
  output logic                           ss_active,
  output logic                           fault,
  output logic [NF-1:0]                  fault_code,
  output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt,
  output logic [2:0]                     state
);

  localparam int RW  = $clog2(MAX_RETRY + 1);
  localparam int DBW = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;

  localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYC - 1);
  localparam logic [CW-1:0]  SS_LAST   = CW'(SS_CYC - 1);
  localparam logic [CW-1:0]  HIC_LAST  = CW'(HICCUP_CYC - 1);
  localparam logic [RW-1:0]  RETRY_MAX = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SS     = 3'd1,
    RUN    = 3'd2,
    HICCUP = 3'd3,
    LATCH  = 3'd4
  } state_t;

  // Synchronized and qualified fault vectors.
  logic [NF-1:0]  sync1;
  logic [NF-1:0]  fs;
  logic [NF-1:0]  fdb;
  logic [DBW-1:0] db_cnt [NF];

  // Sequencer registers and their next values.
  state_t         state_q;
  state_t         state_nx;
  logic [CW-1:0]  timer;
  logic [CW-1:0]  timer_nx;
  logic           timer_run;
  logic [RW-1:0]  retry_nx;
  logic [NF-1:0]  code_nx;
  logic           pwr_en_nx;
  logic           ss_active_nx;
  logic           fault_nx;
  // Low for the first edge after reset release so the sequencer holds IDLE on that edge.
  logic           armed;

  // Two-flop synchronizer on the asynchronous comparator outputs.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge CELCLK or negedge CELRSTN) begin
    if (!CELRSTN) begin
      sync1 <= '0;
      fs    <= '0;
    end else begin
      sync1 <= fault_raw;
      fs    <= sync1;
    end
  end

  // Per-bit debounce: count consecutive synchronized highs, qualify after DB_CYC of them.
  // NOTE: the debounce counter array is a handful of control flops, not a RAM, so it is reset
  // like any other state; a power-up glitch must never look like a qualified fault.
  always_ff @(posedge CELCLK or negedge CELRSTN) begin
    if (!CELRSTN) begin
      for (int i = 0; i < NF; i++) db_cnt[i] <= '0;
      fdb <= '0;
    end else begin
      for (int i = 0; i < NF; i++) begin
        if (!fs[i]) begin
          db_cnt[i] <= '0;
          fdb[i]    <= 1'b0;
        end else begin
          if (db_cnt[i] != DB_LAST) db_cnt[i] <= db_cnt[i] + DBW'(1);
          fdb[i] <= (db_cnt[i] == DB_LAST);
        end
      end
    end
  end

  // State register plus registered outputs, all loaded from their computed next values.
  always_ff @(posedge CELCLK or negedge CELRSTN) begin
    if (!CELRSTN) begin
      armed      <= 1'b0;
      state_q    <= IDLE;
      timer      <= '0;
      retry_cnt  <= '0;
      fault_code <= '0;
      pwr_en     <= 1'b0;
      ss_active  <= 1'b0;
      fault      <= 1'b0;
    end else begin
      armed      <= 1'b1;
      state_q    <= state_nx;
      timer      <= timer_nx;
      retry_cnt  <= retry_nx;
      fault_code <= code_nx;
      pwr_en     <= pwr_en_nx;
      ss_active  <= ss_active_nx;
      fault      <= fault_nx;
    end
  end

  // Next-state logic: transitions, timer, retry counter and sticky fault record.
  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_nx  = state_q;
    retry_nx  = retry_cnt;
    code_nx   = fault_code;
    timer_run = 1'b0;
    if (armed) begin
      unique case (state_q)
        IDLE: begin
          if (clr) code_nx = '0;
          if (en && (fdb == '0)) state_nx = SS;
        end
        SS, RUN: begin
          // Fault beats en=0, which beats soft-start completion.
          if (fdb != '0) begin
            code_nx  = fault_code | fdb;
            state_nx = (retry_cnt < RETRY_MAX) ? HICCUP : LATCH;
          end else if (!en) begin
            state_nx = IDLE;
            retry_nx = '0;
          end else if ((state_q == SS) && (timer == SS_LAST)) begin
            state_nx = RUN;
          end else begin
            timer_run = (state_q == SS);
          end
        end
        HICCUP: begin
          code_nx = fault_code | fdb;
          if (!en) begin
            state_nx = IDLE;
            retry_nx = '0;
          end else if (timer == HIC_LAST) begin
            // A still-present fault restarts the off-time without using a retry.
            if (fdb == '0) begin
              state_nx = SS;
              if (retry_cnt != RETRY_MAX) retry_nx = retry_cnt + RW'(1);
            end
          end else begin
            timer_run = 1'b1;
          end
        end
        LATCH: begin
          if (clr) begin
            state_nx = IDLE;
            code_nx  = '0;
            retry_nx = '0;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
    // Entering a state or hitting a terminal count leaves timer_run low, clearing the timer.
    timer_nx = timer_run ? (timer + CW'(1)) : '0;
  end

  // Output decode from the next state, registered alongside it.
  always_comb begin
    pwr_en_nx    = (state_nx == SS) || (state_nx == RUN);
    ss_active_nx = (state_nx == SS);
    fault_nx     = |code_nx;
  end

  assign state = state_q;

endmodule

// File: tb/tb_stepdown_fault_seq.sv
// Self-checking bench for stepdown_fault_seq: directed scenarios plus randomized traffic,
// compared against a cycle-level behavioural model of the sequencer rules.
module tb_stepdown_fault_seq;

  localparam int NF         = 4;
  localparam int DB_CYC     = 8;
  localparam int SS_CYC     = 256;
  localparam int HICCUP_CYC = 1024;
  localparam int MAX_RETRY  = 3;
  localparam int CW         = 12;
  localparam int RW         = $clog2(MAX_RETRY + 1);
  localparam int VW         = 6 + NF + RW;

  typedef logic [VW-1:0] vec_t;

  logic          CELCLK = 1'b0;
  logic          CELRSTN = 1'b0;
  logic          en = 1'b0;
  logic          clr = 1'b0;
  logic [NF-1:0] fault_raw = '0;
  logic          pwr_en;
  logic          ss_active;
  logic          fault;
  logic [NF-1:0] fault_code;
  logic [RW-1:0] retry_cnt;
  logic [2:0]    state;

  stepdown_fault_seq #(
    .NF(NF), .DB_CYC(DB_CYC), .SS_CYC(SS_CYC), .HICCUP_CYC(HICCUP_CYC),
    .MAX_RETRY(MAX_RETRY), .CW(CW)
  ) dut (
    .CELCLK(CELCLK), .CELRSTN(CELRSTN), .en(en), .fault_raw(fault_raw), .clr(clr),
    .pwr_en(pwr_en), .ss_active(ss_active), .fault(fault), .fault_code(fault_code),
    .retry_cnt(retry_cnt), .state(state)
  );

  always #5 CELCLK = ~CELCLK;

  int checks = 0;
  int passes = 0;

  // ---------------- behavioural model ----------------
  // hist[k] is the raw fault vector sampled k edges ago; a fault is qualified once the DB_CYC
  // samples that have cleared the two synchronizer stages are all high.
  logic [NF-1:0] hist [DB_CYC+2];
  logic [NF-1:0] m_fdb;
  logic [NF-1:0] m_code;
  int            m_state;   // 0 idle, 1 soft-start, 2 run, 3 hiccup, 4 latched
  int            m_left;    // cycles remaining in the current timed phase
  int            m_retry;
  bit            m_first;

  function automatic void model_reset();
    for (int j = 0; j < DB_CYC + 2; j++) hist[j] = '0;
    m_fdb   = '0;
    m_code  = '0;
    m_state = 0;
    m_left  = 0;
    m_retry = 0;
    m_first = 1'b1;
  endfunction

  function automatic void model_step();
    logic [NF-1:0] f;
    f = m_fdb;
    if (m_first) begin
      m_first = 1'b0;
    end else begin
      case (m_state)
        0: begin
          if (clr) m_code = '0;
          if (en && f == '0) begin m_state = 1; m_left = SS_CYC; end
        end
        1, 2: begin
          if (f != '0) begin
            m_code = m_code | f;
            if (m_retry < MAX_RETRY) begin m_state = 3; m_left = HICCUP_CYC; end
            else m_state = 4;
          end else if (!en) begin
            m_state = 0; m_retry = 0;
          end else if (m_state == 1) begin
            if (m_left == 1) m_state = 2;
            else m_left--;
          end
        end
        3: begin
          m_code = m_code | f;
          if (!en) begin
            m_state = 0; m_retry = 0;
          end else if (m_left == 1) begin
            if (f == '0) begin
              m_state = 1; m_left = SS_CYC;
              if (m_retry < MAX_RETRY) m_retry++;
            end else begin
              m_left = HICCUP_CYC;
            end
          end else begin
            m_left--;
          end
        end
        default: begin
          if (clr) begin m_state = 0; m_code = '0; m_retry = 0; end
        end
      endcase
    end
    for (int j = DB_CYC + 1; j > 0; j--) hist[j] = hist[j-1];
    hist[0] = fault_raw;
    m_fdb = '1;
    for (int j = 2; j < DB_CYC + 2; j++) m_fdb = m_fdb & hist[j];
  endfunction

  function automatic vec_t model_vec();
    return {(m_state == 1 || m_state == 2), (m_state == 1), (m_code != '0), m_code,
            RW'(m_retry), 3'(m_state)};
  endfunction

  // One clock: model follows the active edge, bench then sits on the falling edge.
  task automatic tick();
    @(posedge CELCLK);
    if (CELRSTN) model_step();
    @(negedge CELCLK);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    CELRSTN = 1'b0; en = 1'b0; clr = 1'b0; fault_raw = '0;
    model_reset();
    repeat (3) @(negedge CELCLK);
    checks++;
    if ({pwr_en, ss_active, fault, fault_code, retry_cnt, state} !== vec_t'(0))
      $display("FAIL reset_held: outputs=%h required=0",
               {pwr_en, ss_active, fault, fault_code, retry_cnt, state});
    else passes++;
    en = 1'b1;
    CELRSTN = 1'b1;
    tick();
    checks++;
    if (state !== 3'd0 || pwr_en !== 1'b0)
      $display("FAIL reset_first_edge: state=%0d pwr_en=%b required state=0 pwr_en=0", state, pwr_en);
    else passes++;
    tick();
    checks++;
    if (state !== 3'd1 || pwr_en !== 1'b1 || ss_active !== 1'b1)
      $display("FAIL reset_to_ss: state=%0d pwr_en=%b ss=%b required 1/1/1", state, pwr_en, ss_active);
    else passes++;
  endtask

  task automatic test_soft_start();
    int ss_cycles;
    ss_cycles = ss_active ? 1 : 0;
    for (int n = 0; n < SS_CYC + 50 && ss_active; n++) begin
      tick();
      checks++;
      if ({pwr_en, ss_active, fault, fault_code, retry_cnt, state} !== model_vec())
        $display("FAIL ss_model cycle %0d: dut=%h model=%h", n,
                 {pwr_en, ss_active, fault, fault_code, retry_cnt, state}, model_vec());
      else passes++;
      if (ss_active) ss_cycles++;
    end
    checks++;
    if (ss_cycles != SS_CYC || state !== 3'd2 || pwr_en !== 1'b1 || ss_active !== 1'b0)
      $display("FAIL ss_length: cycles=%0d state=%0d pwr_en=%b ss=%b required %0d cycles then RUN",
               ss_cycles, state, pwr_en, ss_active, SS_CYC);
    else passes++;
  endtask

  task automatic test_debounce();
    int lat;
    fault_raw[0] = 1'b1;
    repeat (5) tick();
    fault_raw[0] = 1'b0;
    repeat (15) tick();
    checks++;
    if (fault !== 1'b0 || state !== 3'd2)
      $display("FAIL short_pulse: fault=%b state=%0d required fault=0 state=2", fault, state);
    else passes++;
    fault_raw[0] = 1'b1;
    lat = 0;
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (lat == 0 && pwr_en === 1'b0) lat = n;
    end
    fault_raw[0] = 1'b0;
    checks++;
    if (lat != DB_CYC + 3)
      $display("FAIL fault_latency: clocks=%0d required %0d", lat, DB_CYC + 3);
    else passes++;
    checks++;
    if (state !== 3'd3 || fault_code !== 4'b0001 || fault !== 1'b1 || retry_cnt !== '0)
      $display("FAIL ocp_hiccup: state=%0d code=%b fault=%b retry=%0d required 3/0001/1/0",
               state, fault_code, fault, retry_cnt);
    else passes++;
  endtask

  task automatic test_hiccup_retry();
    for (int n = 0; n < 3000; n++) begin
      if (state === 3'd2) break;
      tick();
    end
    checks++;
    if (state !== 3'd2 || retry_cnt !== RW'(1))
      $display("FAIL hiccup_return: state=%0d retry=%0d required 2/1", state, retry_cnt);
    else passes++;
    fault_raw[0] = 1'b1;
    repeat (2 * HICCUP_CYC + 300) tick();
    checks++;
    if (state !== 3'd3 || retry_cnt !== RW'(1) || pwr_en !== 1'b0)
      $display("FAIL hiccup_held: state=%0d retry=%0d pwr_en=%b required 3/1/0", state, retry_cnt, pwr_en);
    else passes++;
    fault_raw[0] = 1'b0;
    for (int n = 0; n < HICCUP_CYC + 200; n++) begin
      if (state === 3'd1) break;
      tick();
    end
    checks++;
    if (state !== 3'd1 || retry_cnt !== RW'(2))
      $display("FAIL hiccup_release: state=%0d retry=%0d required 1/2", state, retry_cnt);
    else passes++;
    for (int k = 0; k < 4; k++) begin
      fault_raw[0] = 1'b1;
      for (int n = 0; n < 20; n++) begin
        if (state !== 3'd1 && state !== 3'd2) break;
        tick();
      end
      fault_raw[0] = 1'b0;
      if (state === 3'd4) break;
      for (int n = 0; n < HICCUP_CYC + 200; n++) begin
        if (state === 3'd1) break;
        tick();
      end
    end
    checks++;
    if (state !== 3'd4 || retry_cnt !== RW'(MAX_RETRY) || fault_code !== 4'b0001 || pwr_en !== 1'b0)
      $display("FAIL latch_entry: state=%0d retry=%0d code=%b pwr_en=%b required 4/%0d/0001/0",
               state, retry_cnt, fault_code, pwr_en, MAX_RETRY);
    else passes++;
  endtask

  task automatic test_latch();
    for (int n = 0; n < 6; n++) begin
      en = ~en;
      tick();
      checks++;
      if (state !== 3'd4 || pwr_en !== 1'b0)
        $display("FAIL latch_hold %0d: state=%0d pwr_en=%b required 4/0", n, state, pwr_en);
      else passes++;
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if (state !== 3'd0 || fault_code !== '0 || retry_cnt !== '0 || fault !== 1'b0)
      $display("FAIL latch_clear: state=%0d code=%b retry=%0d fault=%b required 0/0000/0/0",
               state, fault_code, retry_cnt, fault);
    else passes++;
    tick();
    checks++;
    if (state !== 3'd1 || pwr_en !== 1'b1)
      $display("FAIL latch_restart: state=%0d pwr_en=%b required 1/1", state, pwr_en);
    else passes++;
  endtask

  task automatic test_fault_vs_en();
    for (int n = 0; n < SS_CYC + 100; n++) begin
      if (state === 3'd2) break;
      tick();
    end
    fault_raw[1] = 1'b1;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (m_fdb[1]) break;
    end
    en = 1'b0;
    tick();
    checks++;
    if (state !== 3'd3 || fault_code !== 4'b0010 || pwr_en !== 1'b0)
      $display("FAIL fault_over_en: state=%0d code=%b pwr_en=%b required 3/0010/0", state, fault_code, pwr_en);
    else passes++;
    tick();
    checks++;
    if (state !== 3'd0 || fault_code !== 4'b0010 || retry_cnt !== '0)
      $display("FAIL en_exit_hiccup: state=%0d code=%b retry=%0d required 0/0010/0", state, fault_code, retry_cnt);
    else passes++;
    fault_raw = '0;
    repeat (20) tick();
    checks++;
    if (fault_code !== 4'b0010 || fault !== 1'b1 || state !== 3'd0)
      $display("FAIL idle_code_kept: code=%b fault=%b state=%0d required 0010/1/0", fault_code, fault, state);
    else passes++;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if (fault_code !== '0 || fault !== 1'b0 || state !== 3'd0)
      $display("FAIL idle_clear: code=%b fault=%b state=%0d required 0000/0/0", fault_code, fault, state);
    else passes++;
  endtask

  task automatic test_reset_mid();
    en = 1'b1;
    repeat (51) tick();
    #2 CELRSTN = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({pwr_en, ss_active, fault, fault_code, retry_cnt, state} !== vec_t'(0))
      $display("FAIL reset_mid_ss: outputs=%h required 0", {pwr_en, ss_active, fault, fault_code, retry_cnt, state});
    else passes++;
    @(negedge CELCLK);
    CELRSTN = 1'b1;
    for (int n = 0; n < SS_CYC + 20; n++) begin
      tick();
      checks++;
      if ({pwr_en, ss_active, fault, fault_code, retry_cnt, state} !== model_vec())
        $display("FAIL reset_resume cycle %0d: dut=%h model=%h", n,
                 {pwr_en, ss_active, fault, fault_code, retry_cnt, state}, model_vec());
      else passes++;
    end
    fault_raw[2] = 1'b1;
    for (int n = 0; n < 20; n++) begin
      if (state === 3'd3) break;
      tick();
    end
    repeat (100) tick();
    checks++;
    if (state !== 3'd3 || fault_code !== 4'b0100)
      $display("FAIL otp_hiccup: state=%0d code=%b required 3/0100", state, fault_code);
    else passes++;
    #2 CELRSTN = 1'b0;
    fault_raw = '0;
    model_reset();
    #1;
    checks++;
    if ({pwr_en, ss_active, fault, fault_code, retry_cnt, state} !== vec_t'(0))
      $display("FAIL reset_mid_hiccup: outputs=%h required 0",
               {pwr_en, ss_active, fault, fault_code, retry_cnt, state});
    else passes++;
    @(negedge CELCLK);
    CELRSTN = 1'b1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 12000; n++) begin
      if (en) begin
        if ($urandom_range(0, 399) == 0) en = 1'b0;
      end else begin
        if ($urandom_range(0, 29) == 0) en = 1'b1;
      end
      clr = ($urandom_range(0, 59) == 0);
      for (int b = 0; b < NF; b++) begin
        if (fault_raw[b]) fault_raw[b] = ($urandom_range(0, 11) != 0);
        else              fault_raw[b] = ($urandom_range(0, 499) == 0);
      end
      tick();
      checks++;
      if ({pwr_en, ss_active, fault, fault_code, retry_cnt, state} !== model_vec())
        $display("FAIL random cycle %0d: dut=%h model=%h", n,
                 {pwr_en, ss_active, fault, fault_code, retry_cnt, state}, model_vec());
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_soft_start();
    test_debounce();
    test_hiccup_retry();
    test_latch();
    test_fault_vs_en();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time budget, %0d/%0d checks passed", passes, checks);
    $fatal(1, "watchdog");
  end

endmodule
